// File: rtl/serie_paralelo_pkg.sv
// Shared state encoding and default alignment/fill symbols for the
// serial-to-parallel deserializer.
package serie_paralelo_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StAlign,
    StActive
  } state_e;

  localparam logic [7:0] DefComma = 8'hBC;
  localparam logic [7:0] DefIdle  = 8'h7C;

endpackage

// File: rtl/serie_paralelo_shift.sv
// Serial shift register, in-word bit counter and the symbol compare flags
// evaluated on the freshly shifted word.
module serie_paralelo_shift
  import serie_paralelo_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(DefComma),
  parameter logic [WIDTH-1:0] IDLE  = WIDTH'(DefIdle)
) (
  input  logic             clk_Nf,
  input  logic             reset,
  input  logic             data_in,
  input  logic             counting,
  output logic [WIDTH-1:0] sr_next,
  output logic             boundary,
  output logic             is_comma,
  output logic             is_idle,
  output logic             is_stuck
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Only WIDTH-1 history bits are kept: the oldest bit would fall off unread.
  logic [WIDTH-2:0] sr;
  logic [CntW-1:0]  bit_cnt;
  logic [CntW-1:0]  bit_cnt_next;

  assign sr_next  = {sr, data_in};
  assign boundary = counting && (bit_cnt == LastBit);
  assign is_comma = (sr_next == COMMA);
  assign is_idle  = (sr_next == IDLE);
  assign is_stuck = (sr_next == '0) || (sr_next == '1);

  // Counter parks at zero while hunting so alignment starts on the next bit.
  always_comb begin
    bit_cnt_next = '0;
    if (counting && !boundary) begin
      bit_cnt_next = bit_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk_Nf) begin
    if (!reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= sr_next[WIDTH-2:0];
      bit_cnt <= bit_cnt_next;
    end
  end

endmodule

// File: rtl/serie_paralelo_param.sv
// Serial-to-parallel deserializer with comma-based word alignment, lock
// acquisition after repeated commas and loss of lock on stuck words.
module serie_paralelo_param
  import serie_paralelo_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DefComma),
  parameter logic [WIDTH-1:0] IDLE       = WIDTH'(DefIdle),
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 4
) (
  input  logic                              clk_Nf,
  input  logic                              reset,
  input  logic                              data_in,
  output logic [WIDTH-1:0]                  data_out,
  output logic                              valid_out,
  output logic                              active,
  output logic                              word_strobe,
  output logic [$clog2(LOCK_COUNT+1)-1:0]   comma_count
);

  localparam int unsigned    CcW      = $clog2(LOCK_COUNT + 1);
  localparam int unsigned    StW      = $clog2(LOSS_COUNT + 1);
  localparam logic [CcW-1:0] LockLast = CcW'(LOCK_COUNT - 1);
  localparam logic [CcW-1:0] LockFull = CcW'(LOCK_COUNT);
  localparam logic [StW-1:0] LossLast = StW'(LOSS_COUNT - 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must lie in 4..16");
  end
  if (LOCK_COUNT < 1 || LOSS_COUNT < 1) begin : g_bad_count
    $error("LOCK_COUNT and LOSS_COUNT must be at least 1");
  end
  if (COMMA == '0 || COMMA == '1 || IDLE == '0 || IDLE == '1) begin : g_bad_symbol
    $error("COMMA and IDLE must not be all-0 or all-1");
  end

  state_e           state;
  logic [StW-1:0]   stuck_cnt;
  logic             counting;
  logic [WIDTH-1:0] sr_next;
  logic             boundary;
  logic             is_comma;
  logic             is_idle;
  logic             is_stuck;

  assign counting = (state != StHunt);

  serie_paralelo_shift #(
    .WIDTH (WIDTH),
    .COMMA (COMMA),
    .IDLE  (IDLE)
  ) u_shift (
    .clk_Nf   (clk_Nf),
    .reset    (reset),
    .data_in  (data_in),
    .counting (counting),
    .sr_next  (sr_next),
    .boundary (boundary),
    .is_comma (is_comma),
    .is_idle  (is_idle),
    .is_stuck (is_stuck)
  );

  always_ff @(posedge clk_Nf) begin
    if (!reset) begin
      state       <= StHunt;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      word_strobe <= 1'b0;
      comma_count <= '0;
      stuck_cnt   <= '0;
    end else begin
      valid_out   <= 1'b0;
      word_strobe <= 1'b0;
      unique case (state)
        StHunt: begin
          if (is_comma) begin
            stuck_cnt <= '0;
            if (LOCK_COUNT == 1) begin
              state       <= StActive;
              active      <= 1'b1;
              comma_count <= LockFull;
            end else begin
              state       <= StAlign;
              comma_count <= CcW'(1);
            end
          end
        end
        StAlign: begin
          if (boundary) begin
            if (is_comma) begin
              word_strobe <= 1'b1;
              if (comma_count == LockLast) begin
                state       <= StActive;
                active      <= 1'b1;
                comma_count <= LockFull;
              end else begin
                comma_count <= comma_count + CcW'(1);
              end
            end else begin
              state       <= StHunt;
              comma_count <= '0;
            end
          end
        end
        StActive: begin
          if (boundary) begin
            // The word that completes the stuck run is dropped with the lock.
            if (is_stuck && stuck_cnt == LossLast) begin
              state       <= StHunt;
              active      <= 1'b0;
              comma_count <= '0;
              stuck_cnt   <= '0;
            end else begin
              word_strobe <= 1'b1;
              stuck_cnt   <= is_stuck ? stuck_cnt + StW'(1) : '0;
              if (!is_comma && !is_idle) begin
                data_out  <= sr_next;
                valid_out <= 1'b1;
              end
            end
          end
        end
        default: state <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_serie_paralelo_param.sv
// Self-checking bench: directed link scenarios plus a randomized bit stream
// compared against a word-level behavioural model.
module tb_serie_paralelo_param;

  logic       clk_Nf = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       word_strobe;
  logic [2:0] comma_count;

  logic       rst10;
  logic       din10;
  logic [9:0] data10;
  logic       valid10;
  logic       active10;
  logic       strobe10;
  logic [0:0] cc10;

  int checks = 0;
  int errors = 0;

  always #5 clk_Nf = ~clk_Nf;

  serie_paralelo_param dut (
    .clk_Nf      (clk_Nf),
    .reset       (rst_n),
    .data_in     (din),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .word_strobe (word_strobe),
    .comma_count (comma_count)
  );

  serie_paralelo_param #(
    .WIDTH      (10),
    .COMMA      (10'h0FA),
    .IDLE       (10'h305),
    .LOCK_COUNT (1),
    .LOSS_COUNT (4)
  ) dut10 (
    .clk_Nf      (clk_Nf),
    .reset       (rst10),
    .data_in     (din10),
    .data_out    (data10),
    .valid_out   (valid10),
    .active      (active10),
    .word_strobe (strobe10),
    .comma_count (cc10)
  );

  // Behavioural model: mode 0 hunting, 1 aligning, 2 locked.
  int         m_mode;
  int         m_since;
  int         m_commas;
  int         m_stucks;
  logic [7:0] m_word;
  logic [7:0] e_data;
  logic       e_valid;
  logic       e_strobe;
  logic       e_active;
  logic [2:0] e_cc;

  task automatic model_step(input logic r, input logic b);
    e_valid  = 1'b0;
    e_strobe = 1'b0;
    if (!r) begin
      m_mode = 0; m_word = 8'h00; m_since = 0; m_commas = 0; m_stucks = 0;
      e_data = 8'h00; e_active = 1'b0; e_cc = 3'd0;
      return;
    end
    m_word = {m_word[6:0], b};
    if (m_mode == 0) begin
      if (m_word == 8'hBC) begin
        m_mode = 1; m_since = 0; m_commas = 1; m_stucks = 0;
      end
    end else begin
      m_since++;
      if (m_since == 8) begin
        m_since = 0;
        if (m_mode == 1) begin
          if (m_word == 8'hBC) begin
            m_commas++;
            e_strobe = 1'b1;
            if (m_commas == 4) m_mode = 2;
          end else begin
            m_mode = 0; m_commas = 0;
          end
        end else begin
          if (m_word == 8'h00 || m_word == 8'hFF) m_stucks++;
          else m_stucks = 0;
          if (m_stucks == 4) begin
            m_mode = 0; m_commas = 0; m_stucks = 0;
          end else begin
            e_strobe = 1'b1;
            if (m_word != 8'hBC && m_word != 8'h7C) begin
              e_data = m_word; e_valid = 1'b1;
            end
          end
        end
      end
    end
    e_active = (m_mode == 2);
    e_cc     = 3'(m_commas);
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk_Nf);
    #1;
    model_step(rst_n, b);
  endtask

  task automatic send_word(input logic [7:0] w, output int nv, output int ns);
    nv = 0;
    ns = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      nv += int'(valid_out);
      ns += int'(word_strobe);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic lock_link();
    int nv, ns;
    apply_reset();
    for (int i = 0; i < 4; i++) send_word(8'hBC, nv, ns);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (word_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", word_strobe); end
    checks++; if (comma_count !== 3'd0) begin errors++; $display("FAIL reset_cc: got %0d expected 0", comma_count); end
  endtask

  task automatic test_lock();
    int nv, ns, tot;
    apply_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    tot = int'(valid_out);
    send_word(8'hBC, nv, ns); tot += nv;
    checks++; if (comma_count !== 3'd1) begin errors++; $display("FAIL lock_cc1: got %0d expected 1", comma_count); end
    send_word(8'hBC, nv, ns); tot += nv;
    send_word(8'hBC, nv, ns); tot += nv;
    checks++; if (active !== 1'b0 || comma_count !== 3'd3) begin
      errors++; $display("FAIL lock_pre: got active=%b cc=%0d expected active=0 cc=3", active, comma_count);
    end
    send_word(8'hBC, nv, ns); tot += nv;
    checks++; if (active !== 1'b1 || comma_count !== 3'd4) begin
      errors++; $display("FAIL lock_active: got active=%b cc=%0d expected active=1 cc=4", active, comma_count);
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL lock_no_valid: got %0d pulses expected 0", tot); end
    send_word(8'hA5, nv, ns);
    checks++; if (valid_out !== 1'b1 || data_out !== 8'hA5 || nv !== 1) begin
      errors++; $display("FAIL lock_data: got valid=%b data=%h pulses=%0d expected valid=1 data=a5 pulses=1", valid_out, data_out, nv);
    end
  endtask

  task automatic test_align_fail();
    int nv, ns, tot;
    apply_reset();
    tot = 0;
    for (int i = 0; i < 3; i++) begin send_word(8'hBC, nv, ns); tot += nv; end
    send_word(8'h12, nv, ns); tot += nv;
    checks++; if (comma_count !== 3'd0 || active !== 1'b0) begin
      errors++; $display("FAIL align_fail: got cc=%0d active=%b expected cc=0 active=0", comma_count, active);
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL align_fail_valid: got %0d pulses expected 0", tot); end
  endtask

  task automatic test_idle_comma();
    int nv, ns;
    lock_link();
    send_word(8'h7C, nv, ns);
    checks++; if (ns !== 1 || word_strobe !== 1'b1 || nv !== 0 || data_out !== 8'h00) begin
      errors++; $display("FAIL idle_word: got strobes=%0d valid=%0d data=%h expected strobes=1 valid=0 data=00", ns, nv, data_out);
    end
    send_word(8'hBC, nv, ns);
    checks++; if (ns !== 1 || word_strobe !== 1'b1 || nv !== 0 || active !== 1'b1 || comma_count !== 3'd4) begin
      errors++; $display("FAIL comma_in_active: got strobes=%0d valid=%0d active=%b cc=%0d expected 1 0 1 4", ns, nv, active, comma_count);
    end
    send_word(8'h3C, nv, ns);
    checks++; if (ns !== 1 || nv !== 1 || valid_out !== 1'b1 || data_out !== 8'h3C) begin
      errors++; $display("FAIL data_3c: got strobes=%0d valid=%0d data=%h expected strobes=1 valid=1 data=3c", ns, nv, data_out);
    end
  endtask

  task automatic test_loss();
    int nv, ns;
    lock_link();
    for (int k = 0; k < 4; k++) begin
      send_word(8'h00, nv, ns);
      if (k < 3) begin
        checks++; if (active !== 1'b1 || nv !== 1) begin
          errors++; $display("FAIL loss_hold%0d: got active=%b valid=%0d expected active=1 valid=1", k, active, nv);
        end
      end else begin
        checks++; if (active !== 1'b0 || nv !== 0 || comma_count !== 3'd0) begin
          errors++; $display("FAIL loss_drop: got active=%b valid=%0d cc=%0d expected 0 0 0", active, nv, comma_count);
        end
      end
    end
    lock_link();
    for (int k = 0; k < 3; k++) send_word(8'h00, nv, ns);
    send_word(8'h55, nv, ns);
    checks++; if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h55) begin
      errors++; $display("FAIL loss_recover: got active=%b valid=%b data=%h expected 1 1 55", active, valid_out, data_out);
    end
  endtask

  task automatic test_reset_mid();
    int nv, ns;
    lock_link();
    send_word(8'hA5, nv, ns);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_bit(1'b1);
      checks++; if ({data_out, valid_out, active, word_strobe, comma_count} !== 14'd0) begin
        errors++; $display("FAIL reset_mid%0d: got data=%h v=%b a=%b s=%b cc=%0d expected all 0", k, data_out, valid_out, active, word_strobe, comma_count);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) send_word(8'hBC, nv, ns);
    checks++; if (active !== 1'b0 || comma_count !== 3'd3) begin
      errors++; $display("FAIL relock_fresh: got active=%b cc=%0d expected 0 3", active, comma_count);
    end
    send_word(8'hBC, nv, ns);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL relock: got active=%b expected 1", active); end
  endtask

  task automatic test_width10();
    logic [9:0] w;
    int nv;
    rst10 = 1'b1;
    w = 10'h0FA;
    nv = 0;
    for (int i = 9; i >= 0; i--) begin
      din10 = w[i]; @(posedge clk_Nf); #1; nv += int'(valid10);
    end
    checks++; if (active10 !== 1'b1 || cc10 !== 1'b1 || nv !== 0) begin
      errors++; $display("FAIL w10_lock: got active=%b cc=%0d valid=%0d expected 1 1 0", active10, cc10, nv);
    end
    w = 10'h2AA;
    nv = 0;
    for (int i = 9; i >= 0; i--) begin
      din10 = w[i]; @(posedge clk_Nf); #1; nv += int'(valid10);
    end
    checks++; if (valid10 !== 1'b1 || data10 !== 10'h2AA || nv !== 1) begin
      errors++; $display("FAIL w10_data: got valid=%b data=%h pulses=%0d expected 1 2aa 1", valid10, data10, nv);
    end
  endtask

  task automatic test_random();
    logic q[$];
    logic [7:0] w;
    int kind, reps;
    logic rst_phase;
    apply_reset();
    for (int n = 0; n < 250; n++) begin
      q.delete();
      rst_phase = 1'b0;
      kind = int'($urandom_range(0, 11));
      if (kind <= 3) begin
        reps = int'($urandom_range(1, 5));
        for (int r = 0; r < reps; r++) for (int i = 7; i >= 0; i--) q.push_back(1'(8'hBC >> i));
      end else if (kind == 4) begin
        for (int i = 7; i >= 0; i--) q.push_back(1'(8'h7C >> i));
      end else if (kind == 5) begin
        reps = int'($urandom_range(1, 5));
        w = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        for (int r = 0; r < reps; r++) for (int i = 7; i >= 0; i--) q.push_back(w[i]);
      end else if (kind == 6) begin
        reps = int'($urandom_range(1, 7));
        for (int r = 0; r < reps; r++) q.push_back(1'($urandom_range(0, 1)));
      end else if (kind == 7 && $urandom_range(0, 3) == 0) begin
        rst_phase = 1'b1;
        reps = int'($urandom_range(1, 2));
        for (int r = 0; r < reps; r++) q.push_back(1'($urandom_range(0, 1)));
      end else begin
        w = 8'($urandom);
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
      end
      rst_n = !rst_phase;
      foreach (q[i]) begin
        send_bit(q[i]);
        checks++; if (data_out !== e_data) begin errors++; $display("FAIL rand_data: got %h expected %h word %0d", data_out, e_data, n); end
        checks++; if (valid_out !== e_valid) begin errors++; $display("FAIL rand_valid: got %b expected %b word %0d", valid_out, e_valid, n); end
        checks++; if (active !== e_active) begin errors++; $display("FAIL rand_active: got %b expected %b word %0d", active, e_active, n); end
        checks++; if (word_strobe !== e_strobe) begin errors++; $display("FAIL rand_strobe: got %b expected %b word %0d", word_strobe, e_strobe, n); end
        checks++; if (comma_count !== e_cc) begin errors++; $display("FAIL rand_cc: got %0d expected %0d word %0d", comma_count, e_cc, n); end
      end
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    rst10 = 1'b0;
    din10 = 1'b0;
    model_step(1'b0, 1'b0);
    test_reset();
    test_lock();
    test_align_fail();
    test_idle_comma();
    test_loss();
    test_reset_mid();
    test_width10();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
